// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: valid/ready upstream, variable-latency dcache port, tohost CSR.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_wb_stage #(
   parameter int          XLEN            = 32,
   parameter logic [11:0] CSR_TOHOST_ADDR = 12'h51E
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_alu_out,
   input  logic [XLEN-1:0]   in_store_data,
   input  logic [XLEN-1:0]   in_rs1,
   output logic              dcache_req_valid,
   input  logic              dcache_req_ready,
   output logic [XLEN-1:0]   dcache_addr,
   output logic [XLEN/8-1:0] dcache_we,
   output logic [XLEN-1:0]   dcache_din,
   input  logic              dcache_resp_valid,
   input  logic [XLEN-1:0]   dcache_dout,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic [XLEN-1:0]   wb_data,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic              exc_valid,
   output logic [3:0]        exc_cause,
`endif
   output logic [XLEN-1:0]   csr_tohost
);
   localparam int NB = XLEN / 8;
   localparam int K  = $clog2(NB);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [1:0] {IDLE, REQ, RESP, WB} state_t;
   state_t state, state_nxt;

   // Encodings that are not legal for this XLEN never touch the cache.
   function automatic logic is_mem(input logic [31:0] i);
      logic ok;
      ok = 1'b0;
      if (i[6:0] == OP_LOAD) begin
         case (i[14:12])
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            3'b011, 3'b110:                         ok = (XLEN == 64);
            default:                                ok = 1'b0;
         endcase
      end else if (i[6:0] == OP_STORE) begin
         case (i[14:12])
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b011:                 ok = (XLEN == 64);
            default:                ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   logic [31:0]     r_inst;
   logic [XLEN-1:0] r_pc, r_addr, r_sdata, r_rs1, load_data;
   logic            r_mem, r_exc;
   logic            accept, acc_mem, acc_exc;

   assign accept  = in_valid && in_ready;
   assign acc_mem = is_mem(in_inst);

`ifdef MEM_MISALIGN_TRAP_EN
   logic [2:0] acc_mask;
   always_comb begin
      case (in_inst[13:12])
         2'd0:    acc_mask = 3'b000;
         2'd1:    acc_mask = 3'b001;
         2'd2:    acc_mask = 3'b011;
         default: acc_mask = 3'b111;
      endcase
   end
   assign acc_exc = acc_mem && ((in_alu_out[2:0] & acc_mask) != 3'b000);
`else
   assign acc_exc = 1'b0;
`endif

   logic [6:0] opc;
   logic [2:0] f3;
   logic [1:0] size;
   logic       r_load;
   assign opc    = r_inst[6:0];
   assign f3     = r_inst[14:12];
   assign size   = f3[1:0];
   assign r_load = r_mem && (opc == OP_LOAD);

   // Misaligned accesses are forced to natural alignment for lanes and selection.
   logic [2:0]   size_mask;
   logic [K-1:0] off;
   always_comb begin
      case (size)
         2'd0:    size_mask = 3'b000;
         2'd1:    size_mask = 3'b001;
         2'd2:    size_mask = 3'b011;
         default: size_mask = 3'b111;
      endcase
   end
   assign off = r_addr[K-1:0] & ~size_mask[K-1:0];

   logic [NB-1:0]   be_base;
   logic [XLEN-1:0] din_rep;
   always_comb begin
      case (size)
         2'd0: begin be_base = NB'(1);  din_rep = {NB{r_sdata[7:0]}};      end
         2'd1: begin be_base = NB'(3);  din_rep = {(NB/2){r_sdata[15:0]}}; end
         2'd2: begin be_base = NB'(15); din_rep = {(NB/4){r_sdata[31:0]}}; end
         default: begin be_base = '1;   din_rep = r_sdata;                 end
      endcase
   end

   logic [XLEN-1:0] shifted, load_ext;
   assign shifted = dcache_dout >> {off, 3'b000};
   always_comb begin
      case (f3)
         3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
         3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
         3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
         3'b100:  load_ext = XLEN'(shifted[7:0]);
         3'b101:  load_ext = XLEN'(shifted[15:0]);
         3'b110:  load_ext = XLEN'(shifted[31:0]);
         default: load_ext = shifted;
      endcase
   end

   logic            is_csr, csr_wr, writes_rd;
   logic [XLEN-1:0] csr_wdata, wb_data_c;
   assign is_csr    = (opc == OP_SYSTEM) && (f3 != 3'b000);
   assign csr_wr    = is_csr && (f3[1:0] == 2'b01) && (r_inst[31:20] == CSR_TOHOST_ADDR);
   assign csr_wdata = f3[2] ? XLEN'(r_inst[19:15]) : r_rs1;

   always_comb begin
      case (opc)
         OP_STORE, OP_BRANCH, OP_FENCE: writes_rd = 1'b0;
         OP_LOAD:                       writes_rd = r_mem;
         OP_SYSTEM:                     writes_rd = is_csr;
         default:                       writes_rd = 1'b1;
      endcase
   end

   always_comb begin
      wb_data_c = r_addr;
      if (opc == OP_JAL || opc == OP_JALR) wb_data_c = r_pc + XLEN'(4);
      else if (r_load)                     wb_data_c = load_data;
      else if (is_csr)                     wb_data_c = csr_tohost;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = (acc_mem && !acc_exc) ? REQ : WB;
         REQ:     if (dcache_req_ready) state_nxt = r_load ? RESP : WB;
         RESP:    if (dcache_resp_valid) state_nxt = WB;
         WB:      state_nxt = in_valid ? ((acc_mem && !acc_exc) ? REQ : WB) : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready         = (state == IDLE) || (state == WB);
      dcache_req_valid = (state == REQ);
      wb_valid         = (state == WB);
      wb_we            = wb_valid && writes_rd && (r_inst[11:7] != 5'd0) && !r_exc;
      wb_rd            = wb_valid ? r_inst[11:7] : 5'd0;
      wb_data          = wb_valid ? wb_data_c : '0;
   end

   assign dcache_addr = {r_addr[XLEN-1:K], {K{1'b0}}};
   assign dcache_we   = (state == REQ && !r_load) ? (be_base << off) : '0;
   assign dcache_din  = din_rep;

`ifdef MEM_MISALIGN_TRAP_EN
   assign exc_valid = wb_valid && r_exc;
   assign exc_cause = (opc == OP_STORE) ? 4'd6 : 4'd4;
`endif

   // The CSR write uses the outgoing instruction even if a new one is accepted this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inst     <= '0;
         r_pc       <= '0;
         r_addr     <= '0;
         r_sdata    <= '0;
         r_rs1      <= '0;
         r_mem      <= 1'b0;
         r_exc      <= 1'b0;
         load_data  <= '0;
         csr_tohost <= '0;
      end else begin
         if (accept) begin
            r_inst  <= in_inst;
            r_pc    <= in_pc;
            r_addr  <= in_alu_out;
            r_sdata <= in_store_data;
            r_rs1   <= in_rs1;
            r_mem   <= acc_mem;
            r_exc   <= acc_exc;
         end
         if (state == RESP && dcache_resp_valid) load_data <= load_ext;
         if (state == WB && csr_wr) csr_tohost <= csr_wdata;
      end
   end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage (XLEN=32) against a transaction-level model.
module tb_mem_wb_stage;
   localparam int XLEN = 32;
   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_inst = '0, in_pc = '0, in_alu_out = '0, in_store_data = '0, in_rs1 = '0;
   logic        dcache_req_valid, dcache_req_ready = 1'b0;
   logic [31:0] dcache_addr, dcache_din, dcache_dout = '0;
   logic [3:0]  dcache_we;
   logic        dcache_resp_valid = 1'b0;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, csr_tohost;
`ifdef MEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
   logic        exc_valid;
   logic [3:0]  exc_cause;
`else
   localparam bit TRAP = 1'b0;
`endif

   int          checks = 0, errors = 0;
   logic [31:0] tohost_m = '0;

   mem_wb_stage #(.XLEN(XLEN), .CSR_TOHOST_ADDR(12'h51E)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .in_alu_out(in_alu_out),
      .in_store_data(in_store_data), .in_rs1(in_rs1),
      .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
      .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_din(dcache_din),
      .dcache_resp_valid(dcache_resp_valid), .dcache_dout(dcache_dout),
      .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef MEM_MISALIGN_TRAP_EN
      .exc_valid(exc_valid), .exc_cause(exc_cause),
`endif
      .csr_tohost(csr_tohost));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] hi);
      return {hi, rs1, f3, rd, opc};
   endfunction

   // Entered and left at a negedge with the DUT idle.
   task automatic do_inst(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] sdata, input logic [31:0] rs1v,
                          input int w, input int d, input logic [31:0] dout);
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [4:0]  rd;
      bit          ld, st, mem, trapped, we_e;
      int          nb, off;
      longint      lv;
      logic [31:0] data_e, mask_e, din_e;
      opc = inst[6:0]; f3 = inst[14:12]; rd = inst[11:7];
      ld  = (opc == 7'h03) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      st  = (opc == 7'h23) && (f3 <= 3'd2);
      mem = ld || st;
      nb  = 1 << (f3 % 4);
      off = ((alu % 4) / nb) * nb;
      trapped = TRAP && mem && ((alu % nb) != 0);
      mask_e  = ((32'd1 << nb) - 1) << off;
      case (nb)
         1:       din_e = sdata[7:0] * 32'h01010101;
         2:       din_e = sdata[15:0] * 32'h00010001;
         default: din_e = sdata;
      endcase
      lv = longint'(dout) >> (8 * off);
      lv = lv & ((longint'(1) << (8 * nb)) - 1);
      if (!f3[2] && lv >= (longint'(1) << (8 * nb - 1))) lv = lv - (longint'(1) << (8 * nb));
      if (opc == 7'h6F || opc == 7'h67) data_e = pc + 32'd4;
      else if (ld)                      data_e = lv[31:0];
      else if (opc == 7'h73 && f3 != 0) data_e = tohost_m;
      else                              data_e = alu;
      if (opc == 7'h73)                                      we_e = (f3 != 0);
      else if (opc == 7'h03)                                 we_e = ld;
      else if (opc inside {7'h23, 7'h63, 7'h0F})             we_e = 1'b0;
      else                                                   we_e = 1'b1;
      we_e = we_e && (rd != 0) && !trapped;

      in_valid = 1'b1; in_inst = inst; in_pc = pc; in_alu_out = alu;
      in_store_data = sdata; in_rs1 = rs1v;
      chk("accept_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      if (mem && !trapped) begin
         for (int i = 0; i <= w; i++) begin
            chk("req_valid", dcache_req_valid, 1'b1);
            chk("req_busy", in_ready, 1'b0);
            chk("req_addr", dcache_addr, alu & ~32'd3);
            chk("req_we", dcache_we, st ? mask_e[3:0] : 4'h0);
            if (st) chk("req_din", dcache_din, din_e);
            dcache_req_ready  = (i == w);
            dcache_resp_valid = (i == w) ? 1'b0 : 1'($urandom_range(0, 1));
            dcache_dout       = $urandom;
            @(negedge clk);
         end
         dcache_req_ready = 1'b0; dcache_resp_valid = 1'b0;
         if (ld) begin
            for (int i = 0; i <= d; i++) begin
               chk("resp_wait_wb", wb_valid, 1'b0);
               chk("resp_wait_req", dcache_req_valid, 1'b0);
               dcache_resp_valid = (i == d);
               dcache_dout       = (i == d) ? dout : $urandom;
               @(negedge clk);
            end
            dcache_resp_valid = 1'b0;
         end
      end
      chk("wb_valid", wb_valid, 1'b1);
      chk("wb_we", wb_we, we_e);
      chk("wb_rd", wb_rd, rd);
      if (!trapped) chk("wb_data", wb_data, data_e);
      chk("wb_noreq", dcache_req_valid, 1'b0);
      chk("wb_ready", in_ready, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("exc_valid", exc_valid, trapped);
      if (trapped) chk("exc_cause", exc_cause, st ? 4'd6 : 4'd4);
`endif
      if (opc == 7'h73 && (f3 == 3'd1 || f3 == 3'd5) && inst[31:20] == 12'h51E)
         tohost_m = (f3 == 3'd5) ? 32'(inst[19:15]) : rs1v;
      @(negedge clk);
      chk("wb_one_cycle", wb_valid, 1'b0);
      chk("tohost", csr_tohost, tohost_m);
   endtask

   task automatic b2b();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_inst = mk(7'h33, 3'd0, 5'(5 + i), 5'd1, 12'h0);
         in_alu_out = 32'h1234 + i;
         @(negedge clk);
         chk("b2b_valid", wb_valid, 1'b1);
         chk("b2b_rd", wb_rd, 5 + i);
         chk("b2b_data", wb_data, 32'h1234 + i);
         chk("b2b_we", wb_we, 1'b1);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_end", wb_valid, 1'b0);
   endtask

   task automatic reset_mid(input bit in_resp);
      in_valid = 1'b1; in_inst = mk(7'h03, 3'd2, 5'd7, 5'd2, 12'h0); in_alu_out = 32'h2000;
      @(negedge clk);
      in_valid = 1'b0;
      if (in_resp) begin
         dcache_req_ready = 1'b1;
         @(negedge clk);
         dcache_req_ready = 1'b0;
      end
      chk("rst_pre_req", dcache_req_valid, !in_resp);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; tohost_m = '0;
      chk("rst_req_drop", dcache_req_valid, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_no_wb", wb_valid, 1'b0);
      dcache_resp_valid = 1'b1; dcache_dout = $urandom;
      @(negedge clk);
      dcache_resp_valid = 1'b0;
      chk("late_resp_wb", wb_valid, 1'b0);
      chk("late_resp_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("late_resp_wb2", wb_valid, 1'b0);
   endtask

   initial begin
      int k;
      logic [2:0]  f3;
      logic [31:0] inst, alu;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_req_valid", dcache_req_valid, 1'b0);
      chk("rst_we", dcache_we, 4'h0);
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_we", wb_we, 1'b0);
      chk("rst_wb_rd", wb_rd, 5'd0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_tohost", csr_tohost, 32'h0);

      b2b();
      do_inst(mk(7'h23, 3'd0, 5'd0, 5'd1, 12'h0), 32'h100, 32'h1003, 32'h55AB, 0, 3, 0, 0);
      do_inst(mk(7'h03, 3'd0, 5'd9, 5'd1, 12'h0), 32'h104, 32'h1002, 0, 0, 0, 1, 32'h00F00000);
      do_inst(mk(7'h03, 3'd4, 5'd9, 5'd1, 12'h0), 32'h108, 32'h1002, 0, 0, 1, 1, 32'h00F00000);
      do_inst(mk(7'h73, 3'd5, 5'd0, 5'd1, 12'h51E), 32'h10C, 0, 0, 0, 0, 0, 0);
      do_inst(mk(7'h6F, 3'd0, 5'd1, 5'd0, 12'h0), 32'hFFFFFFFC, 32'h40, 0, 0, 0, 0, 0);
      do_inst(mk(7'h73, 3'd1, 5'd3, 5'd4, 12'h51E), 32'h110, 0, 0, 32'hCAFE0001, 0, 0, 0);
      reset_mid(1'b0);
      reset_mid(1'b1);

      for (int n = 0; n < 300; n++) begin
         k   = $urandom_range(0, 9);
         f3  = 3'($urandom);
         alu = $urandom;
         case (k)
            0: inst = mk(7'h33, f3, 5'($urandom), 5'($urandom), 12'($urandom));
            1: inst = mk(7'h13, f3, 5'($urandom), 5'($urandom), 12'($urandom));
            2: inst = mk(7'h37, f3, 5'($urandom), 5'($urandom), 12'($urandom));
            3: inst = mk(7'h6F, f3, 5'($urandom), 5'($urandom), 12'($urandom));
            4: inst = mk(7'h67, 3'd0, 5'($urandom), 5'($urandom), 12'($urandom));
            5: inst = mk(7'h63, f3, 5'($urandom), 5'($urandom), 12'($urandom));
            6: begin
               inst = mk(7'h23, 3'($urandom_range(0, 3)), 5'($urandom), 5'($urandom), 12'($urandom));
               alu  = 32'h1000 + $urandom_range(0, 15);
            end
            8: begin
               if (f3 == 3'd0 || f3 == 3'd4) f3 = 3'd1;
               inst = mk(7'h73, f3, 5'($urandom), 5'($urandom),
                         $urandom_range(0, 3) != 0 ? 12'h51E : 12'h300);
            end
            default: begin
               inst = mk(7'h03, f3, 5'($urandom), 5'($urandom), 12'($urandom));
               alu  = 32'h1000 + $urandom_range(0, 15);
            end
         endcase
         do_inst(inst, $urandom, alu, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         if (n % 50 == 0) b2b();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
